// File: rtl/fixed_divider.sv
// fixed_divider: signed radix-2 restoring divider with AXI-Stream operand and result channels.
// One quotient bit is produced per cycle. Each input channel has a one-entry holding register,
// so the next operand pair can be collected while the current division is running.
module fixed_divider #(
    parameter int unsigned DIVIDEND_W = 48,
    parameter int unsigned DIVISOR_W  = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s_axis_dividend_tvalid,
    output logic                  s_axis_dividend_tready,
    input  logic [DIVIDEND_W-1:0] s_axis_dividend_tdata,
    input  logic                  s_axis_divisor_tvalid,
    output logic                  s_axis_divisor_tready,
    input  logic [DIVISOR_W-1:0]  s_axis_divisor_tdata,
    output logic                  m_axis_dout_tvalid,
    input  logic                  m_axis_dout_tready,
    output logic [DIVIDEND_W-1:0] m_axis_dout_tdata,
    output logic [DIVISOR_W-1:0]  m_axis_dout_trem,
    output logic [1:0]            m_axis_dout_tuser
);

    localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0] DVD_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};
    localparam logic [DIVIDEND_W-1:0] DVD_MAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

    // Operand holding registers
    logic                  dvd_full_q;
    logic [DIVIDEND_W-1:0] dvd_hold_q;
    logic                  dvs_full_q;
    logic [DIVISOR_W-1:0]  dvs_hold_q;
    logic                  dvd_accept;
    logic                  dvs_accept;

    // Control
    state_e                state_q;
    state_e                state_d;
    logic                  start;
    logic                  out_load;
    logic [CNT_W-1:0]      cnt_q;

    // Iteration datapath: quo_q starts as |dividend| and is shifted out MSB-first while the
    // quotient bits are shifted in at the LSB.
    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  dvs_mag_q;
    logic                  dvd_neg_q;
    logic                  quo_neg_q;
    logic                  dbz_q;
    logic                  ovf_q;

    logic [DIVIDEND_W-1:0] dvd_mag;
    logic [DIVISOR_W-1:0]  dvs_mag;
    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W:0]    divisor_ext;
    logic                  sub_ok;
    logic [DIVISOR_W-1:0]  rem_step;
    logic [DIVIDEND_W-1:0] quo_step;

    logic [DIVIDEND_W-1:0] quo_fix;
    logic [DIVISOR_W-1:0]  rem_fix;
    logic [1:0]            user_fix;

    // Output register
    logic                  out_valid_q;
    logic [DIVIDEND_W-1:0] out_quo_q;
    logic [DIVISOR_W-1:0]  out_rem_q;
    logic [1:0]            out_user_q;

    assign s_axis_dividend_tready = ~dvd_full_q;
    assign s_axis_divisor_tready  = ~dvs_full_q;
    assign dvd_accept = s_axis_dividend_tvalid & ~dvd_full_q;
    assign dvs_accept = s_axis_divisor_tvalid & ~dvs_full_q;

    // Dividend holding register: filled on handshake, emptied when the FSM consumes the pair.
    // Accept and consume never coincide since accept needs the register empty.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            dvd_full_q <= 1'b0;
            dvd_hold_q <= '0;
        end else begin
            if (start) begin
                dvd_full_q <= 1'b0;
            end
            if (dvd_accept) begin
                dvd_full_q <= 1'b1;
                dvd_hold_q <= s_axis_dividend_tdata;
            end
        end
    end

    // Divisor holding register, same policy as the dividend side.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            dvs_full_q <= 1'b0;
            dvs_hold_q <= '0;
        end else begin
            if (start) begin
                dvs_full_q <= 1'b0;
            end
            if (dvs_accept) begin
                dvs_full_q <= 1'b1;
                dvs_hold_q <= s_axis_divisor_tdata;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start a division when both operands are held, stall in FIX while the
    // output register is occupied and not draining.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        out_load = 1'b0;
        case (state_q)
            StIdle: begin
                if (dvd_full_q && dvs_full_q) begin
                    start   = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (!out_valid_q || m_axis_dout_tready) begin
                    out_load = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Operand magnitudes and one restoring shift/subtract step.
    always_comb begin
        // Negating the most negative value wraps to itself, which is the correct unsigned
        // magnitude 2^(W-1).
        dvd_mag     = dvd_hold_q[DIVIDEND_W-1] ? -dvd_hold_q : dvd_hold_q;
        dvs_mag     = dvs_hold_q[DIVISOR_W-1] ? -dvs_hold_q : dvs_hold_q;
        shifted     = {rem_q, quo_q[DIVIDEND_W-1]};
        divisor_ext = {1'b0, dvs_mag_q};
        sub_ok      = (shifted >= divisor_ext);
        rem_step    = sub_ok ? DIVISOR_W'(shifted - divisor_ext) : shifted[DIVISOR_W-1:0];
        quo_step    = {quo_q[DIVIDEND_W-2:0], sub_ok};
    end

    // Iteration registers: latch magnitudes/signs/flags on start, step once per CALC cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_mag_q <= '0;
            dvd_neg_q <= 1'b0;
            quo_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else if (start) begin
            quo_q     <= dvd_mag;
            rem_q     <= '0;
            dvs_mag_q <= dvs_mag;
            dvd_neg_q <= dvd_hold_q[DIVIDEND_W-1];
            quo_neg_q <= dvd_hold_q[DIVIDEND_W-1] ^ dvs_hold_q[DIVISOR_W-1];
            dbz_q     <= (dvs_hold_q == '0);
            ovf_q     <= (dvd_hold_q == DVD_MIN) && (dvs_hold_q == '1);
            cnt_q     <= CNT_INIT;
        end else if (state_q == StCalc) begin
            quo_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Sign correction and special cases. Overflow needs no override: the magnitude 2^(W-1)
    // with a positive sign already reads as the most negative quotient, remainder zero.
    always_comb begin
        quo_fix  = quo_neg_q ? -quo_q : quo_q;
        rem_fix  = dvd_neg_q ? -rem_q : rem_q;
        user_fix = {dbz_q, ovf_q};
        if (dbz_q) begin
            quo_fix = dvd_neg_q ? DVD_MIN : DVD_MAX;
            rem_fix = '0;
        end
    end

    // Output register: loaded from FIX, cleared on a drain that is not refilled the same edge.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_valid_q <= 1'b0;
            out_quo_q   <= '0;
            out_rem_q   <= '0;
            out_user_q  <= '0;
        end else if (out_load) begin
            out_valid_q <= 1'b1;
            out_quo_q   <= quo_fix;
            out_rem_q   <= rem_fix;
            out_user_q  <= user_fix;
        end else if (out_valid_q && m_axis_dout_tready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign m_axis_dout_tvalid = out_valid_q;
    assign m_axis_dout_tdata  = out_quo_q;
    assign m_axis_dout_trem   = out_rem_q;
    assign m_axis_dout_tuser  = out_user_q;

endmodule

// File: tb/tb_fixed_divider.sv
// tb_fixed_divider: directed and randomised checks of fixed_divider at default widths.
module tb_fixed_divider;

    logic        aclk;
    logic        areset;
    logic        dvd_valid;
    logic        dvd_ready;
    logic [47:0] dvd_data;
    logic        dvs_valid;
    logic        dvs_ready;
    logic [31:0] dvs_data;
    logic        dout_valid;
    logic        m_rdy;
    logic [47:0] dout_data;
    logic [31:0] dout_rem;
    logic [1:0]  dout_user;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_edge = 0;

    fixed_divider #(
        .DIVIDEND_W(48),
        .DIVISOR_W (32)
    ) dut (
        .aclk                  (aclk),
        .areset                (areset),
        .s_axis_dividend_tvalid(dvd_valid),
        .s_axis_dividend_tready(dvd_ready),
        .s_axis_dividend_tdata (dvd_data),
        .s_axis_divisor_tvalid (dvs_valid),
        .s_axis_divisor_tready (dvs_ready),
        .s_axis_divisor_tdata  (dvs_data),
        .m_axis_dout_tvalid    (dout_valid),
        .m_axis_dout_tready    (m_rdy),
        .m_axis_dout_tdata     (dout_data),
        .m_axis_dout_trem      (dout_rem),
        .m_axis_dout_tuser     (dout_user)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic plus the special-case rules.
    task automatic model(input logic [47:0] a, input logic [31:0] b, output logic [47:0] q,
                         output logic [31:0] r, output logic [1:0] u);
        longint sa;
        longint sb;
        longint sq;
        longint sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = (sa >= 0) ? 48'h7FFF_FFFF_FFFF : 48'h8000_0000_0000;
            r = 32'h0;
            u = 2'b10;
        end else begin
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[47:0];
            r  = sr[31:0];
            u  = (sa == -64'sd140737488355328 && sb == -1) ? 2'b01 : 2'b00;
        end
    endtask

    function automatic logic [47:0] rand_dvd();
        int unsigned m;
        int unsigned t;
        m = $urandom_range(0, 9);
        if (m < 4) return {16'($urandom), $urandom};
        else if (m < 7) begin
            t = $urandom_range(0, 2000);
            return 48'(longint'(t) - 1000);
        end else if (m == 7) return 48'h8000_0000_0000;
        else return 48'(longint'($signed($urandom)));
    endfunction

    function automatic logic [31:0] rand_dvs();
        int unsigned m;
        int unsigned t;
        m = $urandom_range(0, 19);
        if (m == 0) return 32'h0;
        else if (m == 1) return 32'hFFFF_FFFF;
        else if (m < 8) begin
            t = $urandom_range(1, 100);
            if ($urandom_range(0, 1) == 1) return 32'(t);
            else return 32'(-int'(t));
        end else if (m == 8) return 32'h8000_0000;
        else return $urandom;
    endfunction

    // Called at a negedge; returns at a negedge. hs_edge = edge count of the completing transfer.
    task automatic send_pair(input logic [47:0] a, input logic [31:0] b, input int dvs_lead);
        bit dvd_done;
        bit dvs_done;
        bit dvd_x;
        bit dvs_x;
        int waitc;
        dvd_done  = 1'b0;
        dvs_done  = 1'b0;
        waitc     = 0;
        dvs_valid = 1'b1;
        dvs_data  = b;
        if (dvs_lead == 0) begin
            dvd_valid = 1'b1;
            dvd_data  = a;
        end
        while (!(dvd_done && dvs_done) && waitc < 2000) begin
            dvd_x = dvd_valid && dvd_ready;
            dvs_x = dvs_valid && dvs_ready;
            @(negedge aclk);
            waitc++;
            if (dvd_x) begin
                dvd_done  = 1'b1;
                dvd_valid = 1'b0;
            end
            if (dvs_x) begin
                dvs_done  = 1'b1;
                dvs_valid = 1'b0;
                if (dvs_lead > 0) check("skew_dvs_tready", 64'(dvs_ready), 64'(0));
            end
            if (dvd_done && dvs_done) hs_edge = cyc;
            if (!dvd_done && !dvd_valid && waitc >= dvs_lead) begin
                dvd_valid = 1'b1;
                dvd_data  = a;
            end
        end
        check("send_done", 64'(dvd_done && dvs_done), 64'(1));
    endtask

    // Waits (bounded) for a result, samples it, and steps past the handshake when m_rdy is high.
    task automatic get_result(output logic [47:0] q, output logic [31:0] r,
                              output logic [1:0] u, output int waits, output int lat);
        waits = 0;
        while (dout_valid !== 1'b1 && waits < 400) begin
            @(negedge aclk);
            waits++;
        end
        check("recv_valid", 64'(dout_valid), 64'(1));
        q   = dout_data;
        r   = dout_rem;
        u   = dout_user;
        lat = cyc - hs_edge;
        if (m_rdy) @(negedge aclk);
    endtask

    task automatic run_one(input string tag, input logic [47:0] a, input logic [31:0] b,
                           input int lead);
        logic [47:0] q;
        logic [31:0] r;
        logic [1:0]  u;
        logic [47:0] eq;
        logic [31:0] er;
        logic [1:0]  eu;
        int w;
        int lat;
        send_pair(a, b, lead);
        get_result(q, r, u, w, lat);
        model(a, b, eq, er, eu);
        check({tag, "_q"}, 64'(q), 64'(eq));
        check({tag, "_rem"}, 64'(r), 64'(er));
        check({tag, "_user"}, 64'(u), 64'(eu));
        check({tag, "_lat"}, 64'(lat), 64'(50));
    endtask

    task automatic run_const(input string tag, input logic [47:0] a, input logic [31:0] b,
                             input logic [47:0] eq, input logic [31:0] er, input logic [1:0] eu);
        logic [47:0] q;
        logic [31:0] r;
        logic [1:0]  u;
        int w;
        int lat;
        send_pair(a, b, 0);
        get_result(q, r, u, w, lat);
        check({tag, "_q"}, 64'(q), 64'(eq));
        check({tag, "_rem"}, 64'(r), 64'(er));
        check({tag, "_user"}, 64'(u), 64'(eu));
        check({tag, "_lat"}, 64'(lat), 64'(50));
    endtask

    logic [47:0] ra [3];
    logic [31:0] rb [3];
    logic [47:0] gq;
    logic [31:0] gr;
    logic [1:0]  gu;
    logic [47:0] eq;
    logic [31:0] er;
    logic [1:0]  eu;
    int          gw;
    int          glat;
    int          start_cyc;
    bit          stable;
    bit          seen;

    initial begin
        areset    = 1'b1;
        dvd_valid = 1'b0;
        dvd_data  = '0;
        dvs_valid = 1'b0;
        dvs_data  = '0;
        m_rdy     = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_dvd_tready", 64'(dvd_ready), 64'(1));
        check("rst_dvs_tready", 64'(dvs_ready), 64'(1));
        check("rst_tvalid", 64'(dout_valid), 64'(0));
        check("rst_tdata", 64'(dout_data), 64'(0));
        check("rst_trem", 64'(dout_rem), 64'(0));
        check("rst_tuser", 64'(dout_user), 64'(0));
        areset = 1'b0;
        @(negedge aclk);

        // Q16.16: 1.5 / 0.5 = 3.0
        run_const("q16", 48'h0001_8000_0000, 32'h0000_8000, 48'h0000_0003_0000, 32'h0, 2'b00);

        // Sign combinations
        run_const("neg_pos", -48'sd7, 32'sd2, -48'sd3, -32'sd1, 2'b00);
        run_const("pos_neg", 48'sd7, -32'sd2, -48'sd3, 32'sd1, 2'b00);
        run_const("neg_neg", -48'sd7, -32'sd2, 48'sd3, -32'sd1, 2'b00);

        // Divide by zero and overflow
        run_const("dbz_pos", 48'sd5, 32'sd0, 48'h7FFF_FFFF_FFFF, 32'h0, 2'b10);
        run_const("dbz_neg", -48'sd5, 32'sd0, 48'h8000_0000_0000, 32'h0, 2'b10);
        run_const("ovf", 48'h8000_0000_0000, 32'hFFFF_FFFF, 48'h8000_0000_0000, 32'h0, 2'b01);

        // Divisor seven cycles ahead of the dividend; latency counted from the dividend edge
        run_one("skew", 48'sd123456789, -32'sd4321, 7);

        // Backpressure: three pairs with the result channel blocked for 120 cycles
        for (int i = 0; i < 3; i++) begin
            ra[i] = rand_dvd();
            rb[i] = rand_dvs();
        end
        m_rdy     = 1'b0;
        start_cyc = cyc;
        for (int i = 0; i < 3; i++) send_pair(ra[i], rb[i], 0);
        model(ra[0], rb[0], eq, er, eu);
        stable = 1'b1;
        while (cyc - start_cyc < 120) begin
            if (dout_valid !== 1'b1 || dout_data !== eq || dout_rem !== er || dout_user !== eu)
                stable = 1'b0;
            @(negedge aclk);
        end
        check("bp_stable", 64'(stable), 64'(1));
        check("bp_dvd_tready", 64'(dvd_ready), 64'(0));
        check("bp_dvs_tready", 64'(dvs_ready), 64'(0));
        m_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            get_result(gq, gr, gu, gw, glat);
            model(ra[i], rb[i], eq, er, eu);
            check($sformatf("bp_r%0d_q", i), 64'(gq), 64'(eq));
            check($sformatf("bp_r%0d_rem", i), 64'(gr), 64'(er));
            check($sformatf("bp_r%0d_user", i), 64'(gu), 64'(eu));
            if (i == 1) check("bp_r1_back_to_back", 64'(gw), 64'(0));
        end
        seen = 1'b0;
        repeat (60) begin
            seen = seen | dout_valid;
            @(negedge aclk);
        end
        check("bp_no_dup", 64'(seen), 64'(0));

        // Reset 20 cycles into CALC with a result parked in the output register
        m_rdy = 1'b0;
        send_pair(48'd100, 32'd7, 0);
        get_result(gq, gr, gu, gw, glat);
        check("pre_rst_q", 64'(gq), 64'(14));
        check("pre_rst_rem", 64'(gr), 64'(2));
        send_pair(48'd1000, 32'd3, 0);
        repeat (21) @(negedge aclk);
        check("pre_rst_tvalid", 64'(dout_valid), 64'(1));
        areset = 1'b1;
        #1;
        check("mid_rst_tvalid", 64'(dout_valid), 64'(0));
        check("mid_rst_tdata", 64'(dout_data), 64'(0));
        check("mid_rst_trem", 64'(dout_rem), 64'(0));
        check("mid_rst_tuser", 64'(dout_user), 64'(0));
        check("mid_rst_dvd_tready", 64'(dvd_ready), 64'(1));
        check("mid_rst_dvs_tready", 64'(dvs_ready), 64'(1));
        @(negedge aclk);
        areset = 1'b0;
        m_rdy  = 1'b1;
        seen   = 1'b0;
        repeat (80) begin
            seen = seen | dout_valid;
            @(negedge aclk);
        end
        check("rst_no_output", 64'(seen), 64'(0));
        run_one("post_rst", -48'sd987654321, 32'sd1234, 0);

        // Randomised pairs against the reference
        for (int i = 0; i < 1000; i++) begin
            run_one("rand", rand_dvd(), rand_dvs(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
